// File: rtl/mor1kx_icache_refill_ctrl.sv
// Icache line refill sequencer: critical-word-first, line-wrapping burst reads forwarded to the icache write port.
// Latency: ibus_req_o rises 1 cycle after the miss is sampled; each acked beat is written to the cache in the same cycle.
// Backpressure: ibus_ack_i low stalls the burst with all outputs and counters held; bus error aborts to ERR until flush.
module mor1kx_icache_refill_ctrl #(
    parameter int OPTION_OPERAND_WIDTH      = 32,
    parameter int OPTION_ICACHE_BLOCK_WIDTH = 5
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            refill_req_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] refill_adr_i,
    input  logic                            flush_i,
    output logic [OPTION_OPERAND_WIDTH-1:0] wradr_o,
    output logic [31:0]                     wrdat_o,
    output logic                            we_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] ibus_adr_o,
    output logic                            ibus_req_o,
    output logic                            ibus_burst_o,
    input  logic                            ibus_ack_i,
    input  logic                            ibus_err_i,
    input  logic [31:0]                     ibus_dat_i,
    output logic                            busy_o,
    output logic                            err_o
);

    localparam int BW    = OPTION_ICACHE_BLOCK_WIDTH;
    localparam int OW    = OPTION_OPERAND_WIDTH;
    localparam int WW    = BW - 2;
    localparam int WORDS = 1 << WW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        ERR   = 2'd2
    } state_t;

    state_t          state;
    logic [OW-BW-1:0] line;
    logic [WW-1:0]   word;
    logic [WW-1:0]   beat;
    logic            last_beat;
    logic            beat_ok;

    // Byte-offset bits of the miss address never reach the bus; words are always whole.
    logic unused_adr_lsb;
    assign unused_adr_lsb = ^refill_adr_i[1:0];

    assign last_beat = (beat == WW'(WORDS - 1));
    // Error takes priority over a simultaneous ack so a faulty beat is never written.
    assign beat_ok   = (state == BURST) && ibus_ack_i && !ibus_err_i;

    // Bus-side outputs come straight from state registers, so reset clears them without a clock.
    always_comb begin
        ibus_adr_o   = {line, word, 2'b00};
        ibus_req_o   = (state == BURST);
        ibus_burst_o = (state == BURST) && !last_beat;
        busy_o       = (state != IDLE);
        err_o        = (state == BURST) && ibus_err_i;
        we_o         = beat_ok;
        wradr_o      = {line, word, 2'b00};
        wrdat_o      = ibus_dat_i;
    end

    // Refill FSM: latch the miss, walk the line wrapping within it, park in ERR on bus error until flushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            line  <= '0;
            word  <= '0;
            beat  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (refill_req_i) begin
                        line  <= refill_adr_i[OW-1:BW];
                        word  <= refill_adr_i[BW-1:2];
                        beat  <= '0;
                        state <= BURST;
                    end
                end
                BURST: begin
                    // flush_i is deliberately ignored here: the line always completes.
                    if (ibus_err_i) begin
                        state <= ERR;
                    end else if (ibus_ack_i) begin
                        word <= word + 1'b1;
                        beat <= beat + 1'b1;
                        if (last_beat) begin
                            state <= IDLE;
                        end
                    end
                end
                ERR: begin
                    if (flush_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mor1kx_icache_refill_ctrl.sv
module tb_mor1kx_icache_refill_ctrl;

    logic        clk;
    logic        rst_n;
    logic        refill_req;
    logic [31:0] refill_adr;
    logic        flush;
    logic        ack;
    logic        err;
    logic [31:0] dat;

    logic [31:0] wradr5, wrdat5, adr5;
    logic        we5, req5, burst5, busy5, err5;
    logic [31:0] wradr4, wrdat4, adr4;
    logic        we4, req4, burst4, busy4, err4;

    int tests;
    int fails;

    mor1kx_icache_refill_ctrl #(
        .OPTION_OPERAND_WIDTH(32),
        .OPTION_ICACHE_BLOCK_WIDTH(5)
    ) u5 (
        .clk(clk), .rst_n(rst_n),
        .refill_req_i(refill_req), .refill_adr_i(refill_adr), .flush_i(flush),
        .wradr_o(wradr5), .wrdat_o(wrdat5), .we_o(we5),
        .ibus_adr_o(adr5), .ibus_req_o(req5), .ibus_burst_o(burst5),
        .ibus_ack_i(ack), .ibus_err_i(err), .ibus_dat_i(dat),
        .busy_o(busy5), .err_o(err5)
    );

    mor1kx_icache_refill_ctrl #(
        .OPTION_OPERAND_WIDTH(32),
        .OPTION_ICACHE_BLOCK_WIDTH(4)
    ) u4 (
        .clk(clk), .rst_n(rst_n),
        .refill_req_i(refill_req), .refill_adr_i(refill_adr), .flush_i(flush),
        .wradr_o(wradr4), .wrdat_o(wrdat4), .we_o(we4),
        .ibus_adr_o(adr4), .ibus_req_o(req4), .ibus_burst_o(burst4),
        .ibus_ack_i(ack), .ibus_err_i(err), .ibus_dat_i(dat),
        .busy_o(busy4), .err_o(err4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] dat_in;
        logic [31:0] exp_adr;
        logic        exp_burst;
    } vec_t;

    vec_t t1[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        refill_req = 1'b0; flush = 1'b0; ack = 1'b0; err = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // Full 8-beat line on the 8-word instance with ack every cycle; optional flush pulse on one beat.
    task automatic run_line5(input logic [31:0] start, input int flush_at);
        logic [31:0] exp;
        refill_req = 1'b1; refill_adr = start; ack = 1'b0;
        @(negedge clk);
        chk("line_req_latency", {31'b0, req5}, 32'd0);
        step();
        refill_req = 1'b0;
        for (int k = 0; k < 8; k++) begin
            ack   = 1'b1;
            dat   = 32'hC0DE0000 | k;
            flush = (k == flush_at);
            @(negedge clk);
            exp = (start & 32'hFFFF_FFE0) | ((start + 32'(4 * k)) & 32'h1F);
            chk("line_adr", adr5, exp);
            chk("line_wradr", wradr5, exp);
            chk("line_we", {31'b0, we5}, 32'd1);
            chk("line_wrdat", wrdat5, 32'hC0DE0000 | k);
            chk("line_burst", {31'b0, burst5}, (k != 7) ? 32'd1 : 32'd0);
            chk("line_err", {31'b0, err5}, 32'd0);
            step();
        end
        ack = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("line_end_req", {31'b0, req5}, 32'd0);
        chk("line_end_busy", {31'b0, busy5}, 32'd0);
        step();
    endtask

    initial begin
        int wecnt;
        logic [31:0] a4[4];

        tests = 0; fails = 0;
        rst_n = 1'b0; refill_req = 1'b0; refill_adr = '0; flush = 1'b0;
        ack = 1'b0; err = 1'b0; dat = '0;

        t1[0] = '{32'h11110000, 32'h1014, 1'b1};
        t1[1] = '{32'h11110001, 32'h1018, 1'b1};
        t1[2] = '{32'h11110002, 32'h101C, 1'b1};
        t1[3] = '{32'h11110003, 32'h1000, 1'b1};
        t1[4] = '{32'h11110004, 32'h1004, 1'b1};
        t1[5] = '{32'h11110005, 32'h1008, 1'b1};
        t1[6] = '{32'h11110006, 32'h100C, 1'b1};
        t1[7] = '{32'h11110007, 32'h1010, 1'b0};
        a4[0] = 32'h200C; a4[1] = 32'h2000; a4[2] = 32'h2004; a4[3] = 32'h2008;

        // Reset state
        #3;
        chk("rst_req", {31'b0, req5}, 32'd0);
        chk("rst_busy", {31'b0, busy5}, 32'd0);
        chk("rst_we", {31'b0, we5}, 32'd0);
        chk("rst_adr", adr5, 32'd0);
        chk("rst_wradr", wradr5, 32'd0);
        step();
        rst_n = 1'b1;

        // Test 1: table-driven 8-word wrapping line, ack every cycle
        refill_req = 1'b1; refill_adr = 32'h1014;
        @(negedge clk);
        chk("t1_req_pre", {31'b0, req5}, 32'd0);
        step();
        refill_req = 1'b0;
        wecnt = 0;
        for (int k = 0; k < 8; k++) begin
            ack = 1'b1; dat = t1[k].dat_in;
            @(negedge clk);
            chk("t1_req", {31'b0, req5}, 32'd1);
            chk("t1_adr", adr5, t1[k].exp_adr);
            chk("t1_wradr", wradr5, t1[k].exp_adr);
            chk("t1_wrdat", wrdat5, t1[k].dat_in);
            chk("t1_burst", {31'b0, burst5}, {31'b0, t1[k].exp_burst});
            if (we5) wecnt++;
            step();
        end
        ack = 1'b0;
        @(negedge clk);
        chk("t1_req_drop", {31'b0, req5}, 32'd0);
        chk("t1_we_count", wecnt, 32'd8);
        step();
        do_reset();

        // Test 2: 4-word line, ack every other cycle
        refill_req = 1'b1; refill_adr = 32'h200C;
        @(negedge clk);
        step();
        refill_req = 1'b0;
        wecnt = 0;
        for (int k = 0; k < 8; k++) begin
            ack = k[0]; dat = 32'h22220000 | k;
            @(negedge clk);
            chk("t2_adr", adr4, a4[k/2]);
            chk("t2_req", {31'b0, req4}, 32'd1);
            chk("t2_we_eq_ack", {31'b0, we4}, {31'b0, ack});
            chk("t2_burst", {31'b0, burst4}, (k/2 != 3) ? 32'd1 : 32'd0);
            if (we4) begin
                wecnt++;
                chk("t2_wradr", wradr4, a4[k/2]);
            end
            step();
        end
        ack = 1'b0;
        @(negedge clk);
        chk("t2_we_count", wecnt, 32'd4);
        chk("t2_req_drop", {31'b0, req4}, 32'd0);
        step();
        do_reset();

        // Test 3: ack+err on third beat, ERR held until flush, then new request
        refill_req = 1'b1; refill_adr = 32'h1014;
        @(negedge clk);
        step();
        refill_req = 1'b0;
        wecnt = 0;
        for (int k = 0; k < 2; k++) begin
            ack = 1'b1;
            @(negedge clk);
            if (we5) wecnt++;
            step();
        end
        ack = 1'b1; err = 1'b1;
        @(negedge clk);
        chk("t3_err_we", {31'b0, we5}, 32'd0);
        chk("t3_err_pulse", {31'b0, err5}, 32'd1);
        chk("t3_we_count", wecnt, 32'd2);
        step();
        ack = 1'b0; err = 1'b0; refill_req = 1'b1; refill_adr = 32'h1008;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("t3_err_req", {31'b0, req5}, 32'd0);
            chk("t3_err_once", {31'b0, err5}, 32'd0);
            chk("t3_err_busy", {31'b0, busy5}, 32'd1);
            step();
        end
        flush = 1'b1;
        @(negedge clk);
        chk("t3_flush_busy", {31'b0, busy5}, 32'd1);
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("t3_idle_busy", {31'b0, busy5}, 32'd0);
        chk("t3_idle_req", {31'b0, req5}, 32'd0);
        step();
        refill_req = 1'b0;
        @(negedge clk);
        chk("t3_new_req", {31'b0, req5}, 32'd1);
        chk("t3_new_adr", adr5, 32'h1008);
        step();
        do_reset();

        // Test 4: back-to-back lines, second wraps inside 0x3000-0x301C
        run_line5(32'h1000, -1);
        run_line5(32'h3004, -1);
        do_reset();

        // Test 5: async reset mid-burst after beat 4, then clean restart
        refill_req = 1'b1; refill_adr = 32'h1014;
        @(negedge clk);
        step();
        refill_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ack = 1'b1;
            step();
        end
        @(negedge clk);
        chk("t5_pre_we", {31'b0, we5}, 32'd1);
        chk("t5_pre_adr", adr5, 32'h1004);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_req", {31'b0, req5}, 32'd0);
        chk("t5_async_we", {31'b0, we5}, 32'd0);
        chk("t5_async_busy", {31'b0, busy5}, 32'd0);
        step();
        ack = 1'b0;
        rst_n = 1'b1;
        run_line5(32'h1014, -1);

        // Test 6: flush during burst has no effect
        run_line5(32'h4018, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
